// File: rtl/vliw_rf_pkg.sv
// vliw_rf_pkg: shared defaults, address-width derivation and packed-bus slice helpers
// for the multi-issue VLIW register file.
package vliw_rf_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_WR = 2;
    localparam int DEF_NUM_RD = 6;
    localparam int CNT_W      = 8;

    function automatic int aw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Base bit of lane idx inside a packed bus of w-bit lanes.
    function automatic int lo_bit(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/vliw_multiport_regfile_if.sv
// vliw_rf_if: decode/writeback-facing bus of the register file; master drives
// writes, reads and reserves, slave is the register file itself.
interface vliw_rf_if #(
    parameter int WIDTH  = vliw_rf_pkg::DEF_WIDTH,
    parameter int DEPTH  = vliw_rf_pkg::DEF_DEPTH,
    parameter int NUM_WR = vliw_rf_pkg::DEF_NUM_WR,
    parameter int NUM_RD = vliw_rf_pkg::DEF_NUM_RD
);
    localparam int AW = vliw_rf_pkg::aw_of(DEPTH);
    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*WIDTH-1:0] wr_data;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_busy;
    logic [NUM_WR-1:0]       rsv_en;
    logic [NUM_WR*AW-1:0]    rsv_addr;
    logic                    conflict_pulse;
    logic [7:0]              conflict_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
        input  rd_data, rd_busy, conflict_pulse, conflict_count
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
        output rd_data, rd_busy, conflict_pulse, conflict_count
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: per-register winning write slot (lowest index wins) and its data,
// plus a flag when any nonzero register is targeted by more than one slot.
module rf_write_arbiter
    import vliw_rf_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_WR = DEF_NUM_WR,
    localparam int AW    = aw_of(DEPTH)
) (
    input  logic [NUM_WR-1:0]                  wr_en,
    input  logic [NUM_WR*AW-1:0]               wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]            wr_data,
    output logic [DEPTH-1:0][NUM_WR-1:0]       win_oh,
    output logic [DEPTH-1:0][WIDTH-1:0]        wr_val,
    output logic                               collision
);
    // Register 0 never gets a winner, so writes to it vanish and never collide.
    always_comb begin
        win_oh    = '0;
        wr_val    = '0;
        collision = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            for (int s = 0; s < NUM_WR; s++) begin
                if (wr_en[s] && wr_addr[lo_bit(s, AW) +: AW] == AW'(r)) begin
                    if (|win_oh[r]) begin
                        collision = 1'b1;
                    end else begin
                        win_oh[r][s] = 1'b1;
                        wr_val[r]    = wr_data[lo_bit(s, WIDTH) +: WIDTH];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/vliw_multiport_regfile.sv
// vliw_multiport_regfile: NUM_WR-write / NUM_RD-read register file with optional
// write-to-read bypass, per-register busy scoreboard and saturating collision counter.
module vliw_multiport_regfile
    import vliw_rf_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int BYPASS = 1
) (
    input logic      clk,
    input logic      reset,
    vliw_rf_if.slave bus
);
    localparam int AW = aw_of(DEPTH);

    logic [DEPTH-1:0][NUM_WR-1:0] win_oh;
    logic [DEPTH-1:0][WIDTH-1:0]  wr_val;
    logic                         collision;
    logic [DEPTH-1:0]             hit;
    logic [WIDTH-1:0]             reg_view [DEPTH];
    logic [DEPTH-1:0]             busy_view;
    logic                         conflict_pulse_q, conflict_pulse_d;
    logic [CNT_W-1:0]             conflict_count_q, conflict_count_d;

    rf_write_arbiter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NUM_WR(NUM_WR)
    ) u_arb (
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.wr_data),
        .win_oh   (win_oh),
        .wr_val   (wr_val),
        .collision(collision)
    );

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        assign hit[r] = |win_oh[r];
        if (r == 0) begin : g_zero
            assign reg_view[r]  = '0;
            assign busy_view[r] = 1'b0;
        end else begin : g_live
            logic [WIDTH-1:0] val_q, val_d;
            logic             busy_q, busy_d, rsv;
            // A reserve in the same cycle as a write names a new producer, so it beats the clear.
            always_comb begin
                rsv = 1'b0;
                for (int s = 0; s < NUM_WR; s++)
                    rsv = rsv | (bus.rsv_en[s] && bus.rsv_addr[lo_bit(s, AW) +: AW] == AW'(r));
                val_d  = hit[r] ? wr_val[r] : val_q;
                busy_d = rsv ? 1'b1 : hit[r] ? 1'b0 : busy_q;
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    val_q  <= '0;
                    busy_q <= 1'b0;
                end else begin
                    val_q  <= val_d;
                    busy_q <= busy_d;
                end
            end
            assign reg_view[r]  = val_q;
            assign busy_view[r] = busy_q;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0] a;
        assign a = bus.rd_addr[lo_bit(j, AW) +: AW];
        assign bus.rd_data[lo_bit(j, WIDTH) +: WIDTH] = (BYPASS != 0 && hit[a]) ? wr_val[a] : reg_view[a];
        assign bus.rd_busy[j] = busy_view[a];
    end

    always_comb begin
        conflict_pulse_d = collision;
        conflict_count_d = (collision && conflict_count_q != '1) ? conflict_count_q + 1'b1 : conflict_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_pulse_q <= 1'b0;
            conflict_count_q <= '0;
        end else begin
            conflict_pulse_q <= conflict_pulse_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign bus.conflict_pulse = conflict_pulse_q;
    assign bus.conflict_count = conflict_count_q;
endmodule

// File: tb/tb_vliw_multiport_regfile.sv
// tb_vliw_multiport_regfile: bypassing and non-bypassing builds driven by the same
// directed stimulus, checked every cycle against an array model plus literal expectations.
module tb_vliw_multiport_regfile;
    localparam int W = 32, D = 8, NW = 2, NR = 6, AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_on = 1'b0;
    int   n_total = 0, n_pass = 0;

    always #5 clk = ~clk;

    vliw_rf_if #(.WIDTH(W), .DEPTH(D), .NUM_WR(NW), .NUM_RD(NR)) b1 ();
    vliw_rf_if #(.WIDTH(W), .DEPTH(D), .NUM_WR(NW), .NUM_RD(NR)) b0 ();

    assign b0.wr_en    = b1.wr_en;
    assign b0.wr_addr  = b1.wr_addr;
    assign b0.wr_data  = b1.wr_data;
    assign b0.rd_addr  = b1.rd_addr;
    assign b0.rsv_en   = b1.rsv_en;
    assign b0.rsv_addr = b1.rsv_addr;

    vliw_multiport_regfile #(.WIDTH(W), .DEPTH(D), .NUM_WR(NW), .NUM_RD(NR), .BYPASS(1))
        dut_byp (.clk(clk), .reset(rst_n), .bus(b1));
    vliw_multiport_regfile #(.WIDTH(W), .DEPTH(D), .NUM_WR(NW), .NUM_RD(NR), .BYPASS(0))
        dut_nob (.clk(clk), .reset(rst_n), .bus(b0));

    // Model: architectural register values, busy bits, pulse and count.
    logic [31:0] m_reg [D];
    bit          m_busy [D];
    bit          m_pulse;
    int          m_cnt;
    int          t_n [D];
    logic [31:0] t_v [D];
    bit          t_coll, t_rsv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < D; a++) begin
                m_reg[a]  <= 32'h0;
                m_busy[a] <= 1'b0;
            end
            m_pulse <= 1'b0;
            m_cnt   <= 0;
        end else begin
            for (int a = 0; a < D; a++) begin
                t_n[a] = 0;
                t_v[a] = 32'h0;
            end
            for (int s = NW - 1; s >= 0; s--)
                if (b1.wr_en[s] && b1.wr_addr[s*AW +: AW] != 0) begin
                    t_n[b1.wr_addr[s*AW +: AW]] += 1;
                    t_v[b1.wr_addr[s*AW +: AW]] = b1.wr_data[s*W +: W];
                end
            t_coll = 1'b0;
            for (int a = 1; a < D; a++) begin
                t_rsv = 1'b0;
                for (int s = 0; s < NW; s++)
                    if (b1.rsv_en[s] && int'(b1.rsv_addr[s*AW +: AW]) == a) t_rsv = 1'b1;
                if (t_n[a] > 0) m_reg[a] <= t_v[a];
                if (t_n[a] > 1) t_coll = 1'b1;
                m_busy[a] <= t_rsv ? 1'b1 : (t_n[a] > 0) ? 1'b0 : m_busy[a];
            end
            m_pulse <= t_coll;
            m_cnt   <= t_coll ? ((m_cnt >= 255) ? 255 : m_cnt + 1) : m_cnt;
        end
    end

    function automatic logic [31:0] exp_rd(input int j, input bit byp);
        int a;
        logic [31:0] v;
        a = int'(b1.rd_addr[j*AW +: AW]);
        if (a == 0) return 32'h0;
        v = m_reg[a];
        if (byp)
            for (int s = NW - 1; s >= 0; s--)
                if (b1.wr_en[s] && int'(b1.wr_addr[s*AW +: AW]) == a) v = b1.wr_data[s*W +: W];
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, idx, $time, got, exp);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int j = 0; j < NR; j++) begin
                chk("byp_rd_data", j, b1.rd_data[j*W +: W], exp_rd(j, 1'b1));
                chk("nob_rd_data", j, b0.rd_data[j*W +: W], exp_rd(j, 1'b0));
                chk("byp_rd_busy", j, 32'(b1.rd_busy[j]), 32'(m_busy[b1.rd_addr[j*AW +: AW]]));
                chk("nob_rd_busy", j, 32'(b0.rd_busy[j]), 32'(m_busy[b1.rd_addr[j*AW +: AW]]));
            end
            chk("byp_pulse", 0, 32'(b1.conflict_pulse), 32'(m_pulse));
            chk("nob_pulse", 0, 32'(b0.conflict_pulse), 32'(m_pulse));
            chk("byp_count", 0, 32'(b1.conflict_count), 32'(m_cnt));
            chk("nob_count", 0, 32'(b0.conflict_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wr();
        b1.wr_en  = '0;
        b1.rsv_en = '0;
    endtask

    task automatic wr(input int s, input int a, input logic [31:0] v);
        b1.wr_en[s]          = 1'b1;
        b1.wr_addr[s*AW +: AW] = AW'(a);
        b1.wr_data[s*W +: W]   = v;
    endtask

    task automatic rsv(input int s, input int a);
        b1.rsv_en[s]            = 1'b1;
        b1.rsv_addr[s*AW +: AW] = AW'(a);
    endtask

    task automatic rd(input int j, input int a);
        b1.rd_addr[j*AW +: AW] = AW'(a);
    endtask

    function automatic logic [31:0] rv1(input int j);
        return b1.rd_data[j*W +: W];
    endfunction

    function automatic logic [31:0] rv0(input int j);
        return b0.rd_data[j*W +: W];
    endfunction

    initial begin
        b1.wr_en = '0; b1.wr_addr = '0; b1.wr_data = '0;
        b1.rd_addr = '0; b1.rsv_en = '0; b1.rsv_addr = '0;
        @(posedge clk);
        #1 chk_on = 1'b1;
        chk("reset_count", 0, 32'(b1.conflict_count), 32'h0);
        #3 rst_n = 1'b1;
        step();

        // Two independent writes, visible through bypass in the write cycle.
        wr(0, 3, 32'h0000_00AA); wr(1, 5, 32'h1234_5678); rd(0, 3); rd(1, 5);
        #1;
        chk("t2_byp_r3", 0, rv1(0), 32'h0000_00AA);
        chk("t2_byp_r5", 1, rv1(1), 32'h1234_5678);
        chk("t2_nob_r3", 0, rv0(0), 32'h0);
        step(); clr_wr(); #1;
        chk("t2_r3", 0, rv0(0), 32'h0000_00AA);
        chk("t2_r5", 1, rv0(1), 32'h1234_5678);

        // Collision on r4: slot 0 wins.
        wr(0, 4, 32'h11); wr(1, 4, 32'h22); rd(2, 4);
        #1 chk("t3_byp_r4", 2, rv1(2), 32'h11);
        step(); clr_wr(); #1;
        chk("t3_pulse", 0, 32'(b1.conflict_pulse), 32'h1);
        chk("t3_count", 0, 32'(b1.conflict_count), 32'h1);
        chk("t3_r4", 2, rv0(2), 32'h11);
        step();
        chk("t3_pulse_end", 0, 32'(b1.conflict_pulse), 32'h0);
        chk("t3_count_hold", 0, 32'(b1.conflict_count), 32'h1);

        // Reserve r6, then reset mid-cycle with everything populated.
        rsv(0, 6); rd(3, 6);
        step(); clr_wr(); #1;
        chk("t5_busy_set", 3, 32'(b1.rd_busy[3]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_r3", 0, rv1(0), 32'h0);
        chk("t1_r5", 1, rv1(1), 32'h0);
        chk("t1_r4", 2, rv1(2), 32'h0);
        chk("t1_busy", 3, 32'(b1.rd_busy), 32'h0);
        chk("t1_count", 0, 32'(b1.conflict_count), 32'h0);
        step();
        #3 rst_n = 1'b1;
        step();

        // Saturation of the collision counter.
        for (int i = 0; i < 300; i++) begin
            wr(0, 4, 32'(i)); wr(1, 4, 32'hDEAD_0000 | 32'(i));
            step();
        end
        clr_wr(); #1;
        chk("t3_count_sat", 0, 32'(b1.conflict_count), 32'd255);
        chk("t3_r4_last", 2, rv0(2), 32'd299);

        // Register 0 ignores writes and reserves and never collides.
        step();
        wr(0, 0, 32'hFFFF_FFFF); wr(1, 0, 32'hFFFF_FFFF); rsv(0, 0); rd(0, 0);
        #1;
        chk("t4_byp_r0", 0, rv1(0), 32'h0);
        chk("t4_busy_r0", 0, 32'(b1.rd_busy[0]), 32'h0);
        step(); clr_wr(); #1;
        chk("t4_r0", 0, rv1(0), 32'h0);
        chk("t4_pulse", 0, 32'(b1.conflict_pulse), 32'h0);
        chk("t4_busy_after", 0, 32'(b1.rd_busy[0]), 32'h0);
        chk("t4_count", 0, 32'(b1.conflict_count), 32'd255);

        // Scoreboard: reserve beats same-edge write, plain write clears.
        rsv(0, 6); rd(3, 6);
        step(); clr_wr(); #1;
        chk("t5_busy", 3, 32'(b1.rd_busy[3]), 32'h1);
        wr(0, 6, 32'h77); rsv(1, 6);
        #1 chk("t5_busy_byp", 3, 32'(b1.rd_busy[3]), 32'h1);
        step(); clr_wr(); #1;
        chk("t5_busy_keep", 3, 32'(b1.rd_busy[3]), 32'h1);
        wr(1, 6, 32'h88);
        step(); clr_wr(); #1;
        chk("t5_busy_clr", 3, 32'(b1.rd_busy[3]), 32'h0);
        chk("t5_r6", 3, rv0(3), 32'h88);

        // Non-bypassing build returns the old value in the write cycle.
        wr(0, 2, 32'h55); rd(4, 2);
        #1;
        chk("t6_nob_old", 4, rv0(4), 32'h0);
        chk("t6_byp_new", 4, rv1(4), 32'h55);
        step(); clr_wr(); #1;
        chk("t6_nob_new", 4, rv0(4), 32'h55);

        // Mixed traffic across all read ports.
        wr(0, 7, 32'hCAFE_F00D); wr(1, 1, 32'h0BAD_BEEF); rsv(1, 7);
        rd(0, 7); rd(1, 1); rd(2, 2); rd(3, 3); rd(4, 6); rd(5, 0);
        step(); clr_wr(); #1;
        chk("mix_r7", 0, rv0(0), 32'hCAFE_F00D);
        chk("mix_r1", 1, rv0(1), 32'h0BAD_BEEF);
        chk("mix_busy7", 0, 32'(b1.rd_busy[0]), 32'h1);
        step();
        step();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
